// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports and the shared single-port dmem port
// that the arbiter sits between.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic              req_0;
  logic              we_0;
  logic [ADDR_W-1:0] addr_0;
  logic [DATA_W-1:0] wdata_0;
  logic              gnt_0;
  logic              rvalid_0;
  logic [DATA_W-1:0] rdata_0;

  logic              req_1;
  logic              we_1;
  logic [ADDR_W-1:0] addr_1;
  logic [DATA_W-1:0] wdata_1;
  logic              gnt_1;
  logic              rvalid_1;
  logic [DATA_W-1:0] rdata_1;

  logic [ADDR_W-1:0] address_dmem;
  logic [DATA_W-1:0] data;
  logic              wren;
  logic [DATA_W-1:0] q_dmem;

  // Requesters plus the memory: everything the arbiter consumes.
  modport master (
    output req_0, we_0, addr_0, wdata_0,
    output req_1, we_1, addr_1, wdata_1,
    output q_dmem,
    input  gnt_0, rvalid_0, rdata_0,
    input  gnt_1, rvalid_1, rdata_1,
    input  address_dmem, data, wren
  );

  modport slave (
    input  req_0, we_0, addr_0, wdata_0,
    input  req_1, we_1, addr_1, wdata_1,
    input  q_dmem,
    output gnt_0, rvalid_0, rdata_0,
    output gnt_1, rvalid_1, rdata_1,
    output address_dmem, data, wren
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single-port dmem: serialises commands onto
// registered address/data/wren and steers each read result to its issuer.
module dmem_arbiter #(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 32,
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic         clock,
  input  logic         reset,
  dmem_arbiter_if.slave bus
);

  logic              elig_0;
  logic              elig_1;
  logic              grant;
  logic              sel_1;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // 1 when requester 1 holds the most recent grant; reset value makes
  // requester 0 win the first contention.
  logic              last_gnt_1;
  logic              tag_valid;
  logic              tag_id;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    // The registered gnt doubles as the one-cycle exclusion flag: a
    // requester granted at the previous edge has not yet retired its command.
    elig_0    = bus.req_0 & ~bus.gnt_0;
    elig_1    = bus.req_1 & ~bus.gnt_1;
    grant     = elig_0 | elig_1;
    sel_1     = elig_1 & (~elig_0 | (ROUND_ROBIN && !last_gnt_1));
    sel_we    = bus.we_0;
    sel_addr  = bus.addr_0;
    sel_wdata = bus.wdata_0;
    if (sel_1) begin
      sel_we    = bus.we_1;
      sel_addr  = bus.addr_1;
      sel_wdata = bus.wdata_1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.gnt_0        <= 1'b0;
      bus.gnt_1        <= 1'b0;
      bus.rvalid_0     <= 1'b0;
      bus.rvalid_1     <= 1'b0;
      bus.rdata_0      <= '0;
      bus.rdata_1      <= '0;
      bus.address_dmem <= '0;
      bus.data         <= '0;
      bus.wren         <= 1'b0;
      tag_valid        <= 1'b0;
      tag_id           <= 1'b0;
      last_gnt_1       <= 1'b1;
    end else begin
      bus.gnt_0 <= grant & ~sel_1;
      bus.gnt_1 <= grant & sel_1;
      bus.wren  <= grant & sel_we;
      tag_valid <= grant & ~sel_we;
      if (grant) begin
        bus.address_dmem <= sel_addr;
        bus.data         <= sel_wdata;
        tag_id           <= sel_1;
        last_gnt_1       <= sel_1;
      end

      // dmem is clocked on the falling edge, so q_dmem now answers the
      // command issued at the previous edge.
      bus.rvalid_0 <= tag_valid & ~tag_id;
      bus.rvalid_1 <= tag_valid & tag_id;
      if (tag_valid && !tag_id) bus.rdata_0 <= bus.q_dmem;
      if (tag_valid && tag_id)  bus.rdata_1 <= bus.q_dmem;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a round-robin instance with a falling-edge
// dmem model, and a fixed-priority instance driven alongside it.
module tb_dmem_arbiter;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;

  logic clock;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
  dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_fp ();

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROUND_ROBIN(1'b1)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROUND_ROBIN(1'b0)) dut_fp (
    .clock (clock),
    .reset (reset),
    .bus   (bus_fp)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Inverted-clock single-port memory; contents are (re)loaded under reset.
  logic [DATA_W-1:0] mem [4096];
  always @(negedge clock) begin
    if (reset) begin
      mem[12'h010] <= 32'hDEAD_BEEF;
      mem[12'h020] <= 32'hA0A0_0020;
      mem[12'h030] <= 32'hB1B1_0030;
      mem[12'h040] <= 32'hC0FF_EE40;
    end else if (bus.wren) begin
      mem[bus.address_dmem] <= bus.data;
    end
    bus.q_dmem <= mem[bus.address_dmem];
  end
  assign bus_fp.q_dmem = '0;

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset       = 1'b1;
    bus.req_0   = 0; bus.we_0 = 0; bus.addr_0 = '0; bus.wdata_0 = '0;
    bus.req_1   = 0; bus.we_1 = 0; bus.addr_1 = '0; bus.wdata_1 = '0;
    bus_fp.req_0 = 0; bus_fp.we_0 = 0; bus_fp.addr_0 = 12'h001; bus_fp.wdata_0 = '0;
    bus_fp.req_1 = 0; bus_fp.we_1 = 0; bus_fp.addr_1 = 12'h002; bus_fp.wdata_1 = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    check("rst_gnt",    {bus.gnt_1, bus.gnt_0}, 2'b00);
    check("rst_rvalid", {bus.rvalid_1, bus.rvalid_0}, 2'b00);
    check("rst_addr",   bus.address_dmem, 0);
    check("rst_wren",   bus.wren, 0);
    check("rst_rdata",  {bus.rdata_1, bus.rdata_0}, 0);

    // Single read by requester 0.
    bus.req_0 = 1; bus.we_0 = 0; bus.addr_0 = 12'h010;
    tick();
    check("rd_gnt",  {bus.gnt_1, bus.gnt_0}, 2'b01);
    check("rd_addr", bus.address_dmem, 12'h010);
    check("rd_wren", bus.wren, 0);
    bus.req_0 = 0;
    tick();
    check("rd_rvalid", {bus.rvalid_1, bus.rvalid_0}, 2'b01);
    check("rd_rdata",  bus.rdata_0, 32'hDEAD_BEEF);
    check("rd_gnt_off", {bus.gnt_1, bus.gnt_0}, 2'b00);

    // Requester 1 writes, requester 0 reads the same address back.
    bus.req_1 = 1; bus.we_1 = 1; bus.addr_1 = 12'h0FF; bus.wdata_1 = 32'h1234_5678;
    tick();
    check("wr_gnt",  {bus.gnt_1, bus.gnt_0}, 2'b10);
    check("wr_wren", bus.wren, 1);
    check("wr_addr", bus.address_dmem, 12'h0FF);
    check("wr_data", bus.data, 32'h1234_5678);
    bus.req_1 = 0; bus.we_1 = 0;
    bus.req_0 = 1; bus.we_0 = 0; bus.addr_0 = 12'h0FF;
    tick();
    check("raw_gnt",    {bus.gnt_1, bus.gnt_0}, 2'b01);
    check("raw_wren",   bus.wren, 0);
    check("wr_norvalid", {bus.rvalid_1, bus.rvalid_0}, 2'b00);
    bus.req_0 = 0;
    tick();
    check("raw_rvalid", {bus.rvalid_1, bus.rvalid_0}, 2'b01);
    check("raw_rdata",  bus.rdata_0, 32'h1234_5678);
    check("raw_rdata1", bus.rdata_1, 0);

    // Last grant was requester 0, so round-robin hands contention to 1.
    bus.req_0 = 1; bus.addr_0 = 12'h020;
    bus.req_1 = 1; bus.we_1 = 0; bus.addr_1 = 12'h030;
    tick();
    check("rr_turn_gnt", {bus.gnt_1, bus.gnt_0}, 2'b10);
    bus.req_0 = 0; bus.req_1 = 0;
    tick();
    check("rr_turn_rvalid", {bus.rvalid_1, bus.rvalid_0}, 2'b10);
    check("rr_turn_rdata",  bus.rdata_1, 32'hB1B1_0030);

    // Fresh reset, then both requesters hold reads for 8 cycles.
    reset = 1'b1;
    #2 reset = 1'b0;
    bus.req_0 = 1; bus.req_1 = 1;
    bus_fp.req_0 = 1; bus_fp.req_1 = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("cont_gnt_%0d", i), {bus.gnt_1, bus.gnt_0},
            (i % 2 == 0) ? 2'b01 : 2'b10);
      check($sformatf("fp_gnt_%0d", i), {bus_fp.gnt_1, bus_fp.gnt_0},
            (i % 2 == 0) ? 2'b01 : 2'b10);
      if (i > 0) begin
        check($sformatf("cont_rvalid_%0d", i), {bus.rvalid_1, bus.rvalid_0},
              (i % 2 == 1) ? 2'b01 : 2'b10);
        if (i % 2 == 1) check($sformatf("cont_rdata0_%0d", i), bus.rdata_0, 32'hA0A0_0020);
        else            check($sformatf("cont_rdata1_%0d", i), bus.rdata_1, 32'hB1B1_0030);
      end
    end
    bus.req_0 = 0; bus.req_1 = 0;
    bus_fp.req_0 = 0; bus_fp.req_1 = 0;
    tick();
    tick();

    // Grant 0 alone, idle, then contend: round-robin picks 1, fixed picks 0.
    bus.req_0 = 1; bus_fp.req_0 = 1;
    tick();
    check("solo_gnt",    {bus.gnt_1, bus.gnt_0}, 2'b01);
    check("fp_solo_gnt", {bus_fp.gnt_1, bus_fp.gnt_0}, 2'b01);
    bus.req_0 = 0; bus_fp.req_0 = 0;
    tick();
    bus.req_0 = 1; bus.req_1 = 1;
    bus_fp.req_0 = 1; bus_fp.req_1 = 1;
    tick();
    check("rr_after_0",  {bus.gnt_1, bus.gnt_0}, 2'b10);
    check("fp_after_0",  {bus_fp.gnt_1, bus_fp.gnt_0}, 2'b01);
    bus.req_0 = 0; bus.req_1 = 0;
    bus_fp.req_0 = 0; bus_fp.req_1 = 0;
    tick();
    tick();

    // Requester 0 never retires: grants every other cycle only.
    bus.req_0 = 1; bus.we_0 = 0; bus.addr_0 = 12'h040;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("excl_gnt_%0d", i), bus.gnt_0, (i % 2 == 0));
      if (i % 2 == 1) check($sformatf("excl_rdata_%0d", i), bus.rdata_0, 32'hC0FF_EE40);
    end
    bus.req_0 = 0;
    tick();
    tick();

    // Reset lands in the grant cycle of a read.
    bus.req_0 = 1; bus.addr_0 = 12'h010;
    tick();
    check("mid_gnt", bus.gnt_0, 1);
    reset = 1'b1;
    #1;
    check("mid_rst_gnt",    {bus.gnt_1, bus.gnt_0}, 2'b00);
    check("mid_rst_addr",   bus.address_dmem, 0);
    check("mid_rst_wren",   bus.wren, 0);
    check("mid_rst_rdata",  {bus.rdata_1, bus.rdata_0}, 0);
    check("mid_rst_rvalid", {bus.rvalid_1, bus.rvalid_0}, 2'b00);
    bus.req_0 = 0;
    @(posedge clock);
    #1 reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check($sformatf("mid_no_rvalid_%0d", i), {bus.rvalid_1, bus.rvalid_0}, 2'b00);
    end
    bus.req_0 = 1; bus.req_1 = 1;
    tick();
    check("post_rst_first", {bus.gnt_1, bus.gnt_0}, 2'b01);
    bus.req_0 = 0; bus.req_1 = 0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter for the single-port data memory (dmem). It shares one dmem port between the processor (requester 0) and a secondary master such as a loader or debug engine (requester 1). It serialises their read and write commands, drives the dmem address/data/wren lines from registers, and routes each registered read result back to the requester that issued it. It sits between the processor's dmem outputs and the dmem instance, in the clock domain of the memory-side logic.

## Interface
Parameters:
- ADDR_W, default 12: dmem address width.
- DATA_W, default 32: dmem data width.
- ROUND_ROBIN, default 1: 1 selects round-robin arbitration; 0 selects fixed priority, with requester 0 always winning.

Ports (x = 0, 1):
- clock, input, 1: the single clock. All state updates on its rising edge.
- reset, input, 1: asynchronous, active-high reset.
- req_x, input, 1: requester x has a command pending. Hold it with the command stable until gnt_x is seen.
- we_x, input, 1: command type. 1 = write, 0 = read.
- addr_x, input, ADDR_W: command address.
- wdata_x, input, DATA_W: write data. Ignored for reads.
- gnt_x, output, 1: the command of requester x was issued this cycle. One-cycle pulse.
- rvalid_x, output, 1: rdata_x holds this requester's read result. One-cycle pulse.
- rdata_x, output, DATA_W: read data. Held between pulses.
- address_dmem, output, ADDR_W: to dmem address.
- data, output, DATA_W: to dmem write data.
- wren, output, 1: to dmem write enable.
- q_dmem, input, DATA_W: from dmem read data.

## Operation
- Arbitration happens at every rising edge, over eligible requesters.
  - Requester x is eligible if req_x=1 and it was not granted at the previous edge.
  - This is the one-cycle exclusion. It prevents re-issuing a command that the requester has not yet retired.
- Winner selection:
  - Only one requester eligible: it wins.
  - Both eligible, ROUND_ROBIN=1: the requester not granted most recently wins. The last-grant pointer updates only on a grant.
  - Both eligible, ROUND_ROBIN=0: requester 0 wins.
- On a grant to x at edge N:
  - Register address_dmem←addr_x, data←wdata_x, wren←we_x.
  - gnt_x=1 for cycle N.
  - Record a pending read tag {valid=~we_x, id=x}.
- No grant at edge N:
  - wren←0.
  - address_dmem and data hold their previous values.
  - Read tag valid←0.
- dmem samples on the falling edge inside cycle N (inverted memory clock), so q_dmem is valid at edge N+1.
- At edge N+1, if the read tag is valid:
  - rdata_id←q_dmem.
  - rvalid_id=1 for cycle N+1.
  - The other requester's rdata is unchanged.
- Requester protocol:
  - On seeing gnt_x at edge N+1, the requester drops req_x or presents a new command.
  - The arbiter ignores req_x at edge N+1, so a new command is eligible no earlier than edge N+2.
- Writes produce no rvalid.
- Read-after-write to the same address returns the new data. This holds for either requester order, because commands are strictly serialised.

## Timing
- Reset (asynchronous, immediate) drives the following to 0:
  - gnt_0, gnt_1, rvalid_0, rvalid_1
  - rdata_0, rdata_1
  - address_dmem, data, wren
  - read tag valid
  - exclusion flags
- Reset sets the last-grant pointer so that requester 0 wins the first contention.
- Reset asserted mid-operation discards an in-flight read. No rvalid is produced for it after release.
- Latency:
  - req to gnt: 1 edge, when eligible and winning.
  - gnt to rvalid: 1 cycle.
  - req to read data: 2 cycles minimum.
- Throughput:
  - One dmem command per cycle aggregate.
  - Per requester: at most one command every 2 cycles.
  - With both requesters continuously requesting under round-robin, grants alternate 0,1,0,1 every cycle.
- At most one gnt and at most one rvalid per cycle. gnt and rvalid may coincide, for the same or different requesters.
- wren is high for exactly the cycle(s) of granted writes and never otherwise.
- Simultaneous first requests after reset: requester 0 wins.
- req dropped before grant: the command is withdrawn and nothing is issued.

## Test plan
- Single read:
  - Stimulus: dmem[0x010]=0xDEADBEEF; req_0=1, we_0=0, addr_0=0x010 before edge 1.
  - Response: gnt_0 in cycle 1; address_dmem=0x010 and wren=0 in cycle 1; rvalid_0=1 with rdata_0=0xDEADBEEF in cycle 2; rvalid_1 stays 0.
- Write then read by the other requester:
  - Stimulus: req_1 writes 0x12345678 to 0x0FF; then req_0 reads 0x0FF.
  - Response: wren=1 only in the gnt_1 cycle; rdata_0=0x12345678 one cycle after gnt_0.
- Contention, round-robin:
  - Stimulus: both requesters hold req with reads to distinct addresses for 8 cycles after reset.
  - Response: grant order 0,1,0,1,…; each rvalid carries the data of its own address; never two gnts in one cycle.
- Fixed priority:
  - Stimulus: ROUND_ROBIN=0; both requesters always requesting.
  - Response: gnt_0 on every other edge; requester 1 is granted only in the cycles where requester 0 is excluded.
- Exclusion:
  - Stimulus: a single requester holds req_0=1 constant (a requester violating the protocol by not retiring).
  - Response: gnt_0 pulses every 2nd cycle, never on consecutive cycles.
- Reset mid-read:
  - Stimulus: assert reset during the gnt cycle of a read.
  - Response: all outputs go to 0 immediately; no rvalid after release; the first contention after release goes to requester 0.
